serial_word_feeder: RTL and testbench
=====================================

Name: serial_word_feeder

Overview:
- Upstream stage of the 11-bit left shift register.
- Accepts a parallel word over a valid/ready handshake and streams it MSB-first into the register's serial input.
- Drives the register's serial data, shift enable and synchronous clear, then pulses done once the whole word has been delivered.
- Sits between the operand source (controller or testbench) and the shift register in the CA1 datapath.

Parameters:
N, 11, word width / number of bits delivered per transfer
CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > N
DIV, 1, clock cycles per delivered bit (pacing); DIV >= 1
DIV_W, 4, pace-counter width; must satisfy 2^DIV_W >= DIV

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-low reset
abort  input  1  synchronous abort, active-high
in_valid  input  1  source presents in_data
in_data  input  N  word to serialize
in_ready  output  1  feeder can accept a word
ser_out  output  1  serial bit; connect to shift register ser_in
shift_en  output  1  shift strobe; connect to shift register shift_s
sclr_out  output  1  clear strobe; connect to shift register sclr
busy  output  1  transfer in progress (CLEAR or SHIFT state)
done  output  1  one-cycle pulse after the last bit has been shifted

Behaviour:
- Reset (clr=0, asynchronous):
  - State goes to IDLE.
  - Hold register, bit counter and pace counter are cleared.
  - in_ready=1; ser_out=0, shift_en=0, sclr_out=0, busy=0, done=0.
- All outputs are Moore decodes of registered state, hold[N-1] and the counters. No input-to-output combinational path.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1 and abort=0: hold <= in_data, next state CLEAR.
  - in_data is ignored while in_ready=0.
- CLEAR (exactly 1 cycle):
  - sclr_out=1, busy=1, in_ready=0.
  - Bit counter and pace counter are set to 0.
  - Next state SHIFT.
- SHIFT:
  - busy=1; ser_out=hold[N-1].
  - shift_en=1 in every cycle where pace counter == DIV-1. With DIV=1, shift_en is high on every SHIFT cycle.
  - Pace counter increments each cycle and wraps to 0 in the same cycle that shift_en=1.
  - On an edge with shift_en=1: hold <= {hold[N-2:0],1'b0} and bit counter increments.
  - When shift_en=1 and bit counter == N-1: next state DONE.
  - Exactly N shift_en pulses are issued per word.
- DONE (exactly 1 cycle):
  - done=1, in_ready=0, busy=0, ser_out=0.
  - Next state IDLE. A new word can be accepted no earlier than the following cycle.
- Latency, handshake edge at T:
  - T+1 is CLEAR.
  - T+2 .. T+1+N*DIV is SHIFT.
  - T+2+N*DIV is DONE.
  - in_ready is high again at T+3+N*DIV.
- ser_out, shift_en and sclr_out are 0 in every state other than the ones where they are defined above.
- abort=1:
  - From any state, next state is IDLE and counters are cleared.
  - done is not pulsed; the downstream register keeps its partial contents.
  - abort has priority over handshake acceptance: in IDLE, in_valid=1 with abort=1 does not capture.
- clr asserted mid-transfer: immediate return to the reset values; no done pulse.
- in_valid held high across a DONE cycle: the next word is accepted on the first IDLE edge, not during DONE.
- Back-to-back words: each is preceded by its own CLEAR pulse.

Test Plan:
- N=11, DIV=1, in_data=11'h5A3, held one cycle with in_ready=1 -> sclr_out 1 cycle; 11 consecutive shift_en pulses; ser_out sequence 1,0,1,1,0,1,0,0,0,1,1; done at T+13; downstream register reads 11'h5A3.
- DIV=3, in_data=11'h7FF -> shift_en once every 3 cycles, 11 pulses over 33 SHIFT cycles; ser_out=1 throughout SHIFT; done at T+35; register reads 11'h7FF.
- abort asserted on the 5th shift_en cycle of 11'h400 -> next cycle IDLE, in_ready=1, no done pulse; total shift_en count is 5.
- clr driven low during SHIFT between clock edges -> outputs immediately return to reset values (in_ready=1, all others 0); the next word after release completes normally.
- in_valid held high with words 11'h001 then 11'h2AA -> second accepted one cycle after DONE; two sclr_out pulses and two done pulses; register ends at 11'h2AA.
- in_valid=1 and abort=1 together in IDLE -> no capture, state stays IDLE, sclr_out stays 0.

Source files
------------

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end for the 11-bit left shift register: takes a word over
// valid/ready, clears the register, then streams the word MSB-first at one bit per DIV cycles.
module serial_word_feeder #(
    parameter int N     = 11,
    parameter int CNT_W = 4,
    parameter int DIV   = 1,
    parameter int DIV_W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         abort,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         ser_out,
    output logic         shift_en,
    output logic         sclr_out,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [DIV_W-1:0] PACE_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(N - 1);

    state_t             state_q, state_d;
    logic [N-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   pace_cnt_q, pace_cnt_d;
    logic               shift_strobe;

    // Strobe is a pure decode of registered state so no input reaches any output.
    assign shift_strobe = (state_q == S_SHIFT) && (pace_cnt_q == PACE_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            bit_cnt_q  <= '0;
            pace_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            bit_cnt_q  <= bit_cnt_d;
            pace_cnt_q <= pace_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        bit_cnt_d  = bit_cnt_q;
        pace_cnt_d = pace_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                bit_cnt_d  = '0;
                pace_cnt_d = '0;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                if (shift_strobe) begin
                    pace_cnt_d = '0;
                    hold_d     = {hold_q[N-2:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = S_DONE;
                    end
                end else begin
                    pace_cnt_d = pace_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a capture in IDLE.
        if (abort) begin
            state_d    = S_IDLE;
            hold_d     = hold_q;
            bit_cnt_d  = '0;
            pace_cnt_d = '0;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign sclr_out = (state_q == S_CLEAR);
    assign busy     = (state_q == S_CLEAR) || (state_q == S_SHIFT);
    assign done     = (state_q == S_DONE);
    assign ser_out  = (state_q == S_SHIFT) && hold_q[N-1];
    assign shift_en = shift_strobe;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboarded bench: two feeders (DIV=1 and DIV=3) each drive a modelled 11-bit shift
// register; expected words and done cycles are queued by the stimulus and checked on done.
module tb_serial_word_feeder;

    typedef struct {
        int          inst;
        logic [10:0] word;
        int          done_cyc;
    } exp_t;

    logic        clk;
    logic        clr;
    logic [1:0]  in_valid;
    logic [1:0]  abort_s;
    logic [10:0] in_data [2];
    logic [1:0]  in_ready_o, ser_o, shift_o, sclr_o, busy_o, done_o;

    exp_t exp_q[$];
    int   cyc = 0;
    int   s_pass = 0;
    int   s_total = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            localparam int DV = (gi == 0) ? 1 : 3;
            logic [10:0] reg_m = '0;
            int shift_cnt = 0;
            int sclr_cnt  = 0;
            int m_pass    = 0;
            int m_total   = 0;

            serial_word_feeder #(.N(11), .CNT_W(4), .DIV(DV), .DIV_W(4)) dut (
                .clk      (clk),
                .clr      (clr),
                .abort    (abort_s[gi]),
                .in_valid (in_valid[gi]),
                .in_data  (in_data[gi]),
                .in_ready (in_ready_o[gi]),
                .ser_out  (ser_o[gi]),
                .shift_en (shift_o[gi]),
                .sclr_out (sclr_o[gi]),
                .busy     (busy_o[gi]),
                .done     (done_o[gi])
            );

            // Monitor: models the downstream register and checks each done pulse.
            initial begin
                exp_t h;
                forever begin
                    @(negedge clk);
                    if (sclr_o[gi]) begin
                        reg_m = '0;
                        sclr_cnt++;
                    end
                    if (shift_o[gi]) begin
                        reg_m = {reg_m[9:0], ser_o[gi]};
                        shift_cnt++;
                    end
                    if (done_o[gi]) begin
                        if (exp_q.size() == 0 || exp_q[0].inst != gi) begin
                            m_total++;
                            $display("FAIL unexpected_done inst%0d: done=1 at cycle %0d, required no done", gi, cyc);
                        end else begin
                            h = exp_q.pop_front();
                            m_total++;
                            if (reg_m == h.word) m_pass++;
                            else $display("FAIL reg_word inst%0d: got %03h required %03h", gi, reg_m, h.word);
                            m_total++;
                            if (cyc == h.done_cyc) m_pass++;
                            else $display("FAIL done_cycle inst%0d: got %0d required %0d", gi, cyc, h.done_cyc);
                        end
                        $display("inst%0d done word=%03h cycle=%0d", gi, reg_m, cyc);
                    end
                end
            end
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        s_total++;
        if (act == req) s_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic send(input int k, input logic [10:0] w, input bit do_push, input int div,
                        output int e);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid[k] = 1'b1;
        in_data[k]  = w;
        @(negedge clk);
        while (!in_ready_o[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("handshake_timeout", 32'(n), 32'd0);
        e = cyc + 1;
        if (do_push) exp_q.push_back('{k, w, e + 1 + 11 * div});
        $display("inst%0d send word=%03h handshake_edge=%0d", k, w, e);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int e, e1, base_sh, base_sc;
        clr      = 1'b0;
        in_valid = '0;
        abort_s  = '0;
        in_data[0] = '0;
        in_data[1] = '0;

        #2;
        chk("reset_outs_0", {26'd0, in_ready_o[0], ser_o[0], shift_o[0], sclr_o[0], busy_o[0], done_o[0]}, 32'b100000);
        chk("reset_outs_1", {26'd0, in_ready_o[1], ser_o[1], shift_o[1], sclr_o[1], busy_o[1], done_o[1]}, 32'b100000);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;

        // Basic word, DIV=1.
        base_sh = g_inst[0].shift_cnt;
        base_sc = g_inst[0].sclr_cnt;
        send(0, 11'h5A3, 1'b1, 1, e);
        drain();
        chk("5a3_shift_count", 32'(g_inst[0].shift_cnt - base_sh), 32'd11);
        chk("5a3_sclr_count", 32'(g_inst[0].sclr_cnt - base_sc), 32'd1);

        // in_valid with abort in IDLE must not capture.
        @(posedge clk); #1;
        in_valid[0] = 1'b1; abort_s[0] = 1'b1; in_data[0] = 11'h3FF;
        repeat (3) begin
            @(negedge clk);
            chk("idle_abort_no_capture", {29'd0, in_ready_o[0], sclr_o[0], busy_o[0]}, 32'b100);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0; abort_s[0] = 1'b0;

        // Abort on the 5th shift.
        base_sh = g_inst[0].shift_cnt;
        send(0, 11'h400, 1'b0, 1, e);
        repeat (5) @(posedge clk);
        #1 abort_s[0] = 1'b1;
        @(negedge clk);
        chk("abort_on_5th_shift_en", 32'(shift_o[0]), 32'd1);
        @(posedge clk); #1 abort_s[0] = 1'b0;
        @(negedge clk);
        chk("abort_idle", {29'd0, in_ready_o[0], busy_o[0], done_o[0]}, 32'b100);
        repeat (15) @(negedge clk);
        chk("abort_shift_count", 32'(g_inst[0].shift_cnt - base_sh), 32'd5);
        chk("abort_partial_reg", 32'(g_inst[0].reg_m), 32'h010);

        // Asynchronous clr mid-transfer, then a normal word.
        send(0, 11'h0F0, 1'b0, 1, e);
        repeat (3) @(posedge clk);
        #3 clr = 1'b0;
        #1;
        chk("clr_async_outs", {26'd0, in_ready_o[0], ser_o[0], shift_o[0], sclr_o[0], busy_o[0], done_o[0]}, 32'b100000);
        @(posedge clk); #1 clr = 1'b1;
        send(0, 11'h155, 1'b1, 1, e);
        drain();

        // in_valid held high across DONE: second word taken on the first IDLE edge.
        base_sc = g_inst[0].sclr_cnt;
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = 11'h001;
        @(negedge clk);
        chk("held_ready", 32'(in_ready_o[0]), 32'd1);
        e1 = cyc + 1;
        exp_q.push_back('{0, 11'h001, e1 + 12});
        exp_q.push_back('{0, 11'h2AA, e1 + 14 + 12});
        @(posedge clk); #1 in_data[0] = 11'h2AA;
        while (cyc < e1 + 14) @(posedge clk);
        #1 in_valid[0] = 1'b0;
        drain();
        chk("held_sclr_count", 32'(g_inst[0].sclr_cnt - base_sc), 32'd2);
        chk("held_final_reg", 32'(g_inst[0].reg_m), 32'h2AA);

        // DIV=3 pacing.
        base_sh = g_inst[1].shift_cnt;
        send(1, 11'h7FF, 1'b1, 3, e);
        drain();
        chk("div3_shift_count", 32'(g_inst[1].shift_cnt - base_sh), 32'd11);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed",
                 s_pass + g_inst[0].m_pass + g_inst[1].m_pass,
                 s_total + g_inst[0].m_total + g_inst[1].m_total);
        $finish;
    end

endmodule
